// File: rtl/load_store_unit.sv
// Load/store bridge between the execute stage and a word-organised data memory.
// One request in flight; faulty requests are answered directly and never reach memory.
module load_store_unit #(
    parameter int ADDR_W = 12,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0] state;
    logic       store_q;
    logic [2:0] funct3_q;
    logic [1:0] lane_q;
    logic       req_err;

    function automatic logic access_err(input logic st, input logic [2:0] f3,
                                        input logic [XLEN-1:0] addr);
        logic illegal;
        logic misaligned;
        logic out_of_range;
        if (st)
            illegal = (f3 > 3'b010);
        else
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                       ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = |addr[XLEN-1:ADDR_W+2];
        return illegal || misaligned || out_of_range;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the data across lanes lets the byte enables pick the target lane.
    function automatic logic [XLEN-1:0] store_data(input logic [1:0] size,
                                                   input logic [XLEN-1:0] wdata);
        case (size)
            2'b00:   return {(XLEN/8){wdata[7:0]}};
            2'b01:   return {(XLEN/16){wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                    input logic [XLEN-1:0] word);
        logic [XLEN-1:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  return sh;
            3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
            default: return '0;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign req_err   = access_err(req_store, req_funct3, req_addr);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            funct3_q   <= '0;
            lane_q     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we     <= 1'b0;
            mem_be     <= '0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        lane_q   <= req_addr[1:0];
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            // Memory strobes are registered here so they are live during ACCESS.
                            state    <= ACCESS;
                            mem_addr <= req_addr[ADDR_W+1:2];
                            if (req_store) begin
                                mem_we    <= 1'b1;
                                mem_be    <= store_be(req_funct3[1:0], req_addr[1:0]);
                                mem_wdata <= store_data(req_funct3[1:0], req_wdata);
                            end
                        end
                    end
                end
                ACCESS: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= store_q ? '0 : load_extend(funct3_q, lane_q, mem_rdata);
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: byte-level reference memory and access rules
// modelled independently, plus directed cases for lanes, errors, back-to-back and reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_W(12), .XLEN(32)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Device-side word memory, preloaded through a side port so it has a single writer.
    logic [31:0] mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_we)
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    // Monotonic activity counters; users take differences.
    int          we_cnt = 0;
    int          be_cnt = 0;
    int          acc_cnt = 0;
    logic [11:0] mon_addr = '0;
    logic [3:0]  mon_be = '0;
    logic [31:0] mon_wdata = '0;

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt    <= we_cnt + 1;
            mon_addr  <= mem_addr;
            mon_be    <= mem_be;
            mon_wdata <= mem_wdata;
        end
        if (mem_be != 4'b0000) be_cnt <= be_cnt + 1;
    end

    always @(posedge clk)
        if (arst_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;

    // Reference model: byte-addressed memory of the whole 16 KiB space.
    logic [7:0] ref_b [0:16383];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int   size;
        logic legal;
        size = 1 << f3[1:0];
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        return !legal || ((a % 32'(size)) != 0) || (a >= 32'h4000);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        v = 0;
        for (int k = 0; k < size; k++) v = v | (32'(ref_b[a + 32'(k)]) << (8 * k));
        if (!f3[2] && size < 4 && v >= (32'd1 << (8 * size - 1)))
            v = v - (32'd1 << (8 * size));
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int size;
        size = 1 << f3[1:0];
        for (int k = 0; k < size; k++) ref_b[a + 32'(k)] = 8'(d >> (8 * k));
    endtask

    logic [31:0] last_rd;
    logic        last_err;
    int          last_lat;

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int wes, output int bes);
        int  we0, be0;
        bit  found;
        @(negedge clk);
        we0 = we_cnt; be0 = be_cnt;
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        found = 0; last_lat = 99; last_rd = '0; last_err = 1'b0;
        for (int i = 1; i <= 6 && !found; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                found = 1; last_lat = i; last_rd = resp_rdata; last_err = resp_err;
            end
        end
        #1;
        wes = we_cnt - we0;
        bes = be_cnt - be0;
    endtask

    task automatic exec(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          wes, bes, exp_w;
        exp_err = model_err(st, f3, a);
        exp_rd  = (!exp_err && !st) ? model_load(f3, a) : 32'h0;
        exp_w   = (st && !exp_err) ? 1 : 0;
        do_req(st, f3, a, d, wes, bes);
        check("resp_err", 32'(last_err), 32'(exp_err));
        check("resp_rdata", last_rd, exp_rd);
        check("latency", 32'(last_lat), exp_err ? 32'd1 : 32'd2);
        check("we_cycles", 32'(wes), 32'(exp_w));
        check("be_cycles", 32'(bes), 32'(exp_w));
        if (st && !exp_err) model_store(f3, a, d);
    endtask

    initial begin
        int          a0, fl, sl, acc_first;
        logic [31:0] rd2;
        logic        rv;

        // Preload while reset is held; words 0 and 1 carry a known pattern.
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 12'(w);
            pre_data = (w < 2) ? 32'h80FF_1234 : $urandom;
            for (int k = 0; k < 4; k++) ref_b[4*w + k] = pre_data[8*k +: 8];
        end
        @(negedge clk);
        pre_we = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        arst_n = 1'b1;

        // Lane selection and extension on the known pattern.
        exec(1'b0, 3'b000, 32'h7, 32'h0);
        check("lb_0x7", last_rd, 32'hFFFF_FF80);
        exec(1'b0, 3'b100, 32'h7, 32'h0);
        check("lbu_0x7", last_rd, 32'h0000_0080);
        exec(1'b0, 3'b101, 32'h2, 32'h0);
        check("lhu_0x2", last_rd, 32'h0000_80FF);

        // Byte store to lane 2 of word 1.
        exec(1'b1, 3'b000, 32'h6, 32'h0000_00A5);
        check("sb_mem_addr", 32'(mon_addr), 32'd1);
        check("sb_mem_be", 32'(mon_be), 32'h4);
        check("sb_mem_wdata", mon_wdata, 32'hA5A5_A5A5);
        check("sb_err", 32'(last_err), 32'd0);

        // Error paths.
        exec(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        check("lw_mis_err", 32'(last_err), 32'd1);
        exec(1'b1, 3'b011, 32'h0000_0040, 32'hFFFF_FFFF);
        check("st_f3_err", 32'(last_err), 32'd1);
        exec(1'b0, 3'b010, 32'h0001_0000, 32'h0);
        check("ld_oor_err", 32'(last_err), 32'd1);

        // Back-to-back with req_valid held high.
        a0 = acc_cnt; fl = 0; sl = 0; acc_first = 0; rd2 = '0;
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
        req_wdata = 32'h1234_5678; req_valid = 1'b1;
        @(posedge clk);
        #1 req_store = 1'b0; req_wdata = 32'h0;
        for (int i = 1; i <= 12 && sl == 0; i++) begin
            @(negedge clk);
            if (acc_cnt - a0 >= 2) req_valid = 1'b0;
            if (resp_valid) begin
                if (fl == 0) begin fl = i; acc_first = acc_cnt - a0; end
                else begin sl = i; rd2 = resp_rdata; end
            end
        end
        req_valid = 1'b0;
        check("b2b_first_lat", 32'(fl), 32'd2);
        check("b2b_not_accepted_busy", 32'(acc_first), 32'd1);
        check("b2b_second_lat", 32'(sl), 32'd5);
        check("b2b_load_data", rd2, 32'h1234_5678);
        check("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
        model_store(3'b010, 32'h10, 32'h1234_5678);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            exec(st, f3, a, $urandom);
        end

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20;
        req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_access_we", 32'(mem_we), 32'd1);
        arst_n = 1'b0;
        #1;
        check("rst_async_we", 32'(mem_we), 32'd0);
        check("rst_async_be", 32'(mem_be), 32'd0);
        check("rst_async_ready", 32'(req_ready), 32'd1);
        rv = resp_valid;
        repeat (2) begin @(negedge clk); rv = rv | resp_valid; end
        arst_n = 1'b1;
        repeat (3) begin @(negedge clk); rv = rv | resp_valid; end
        check("rst_no_resp", 32'(rv), 32'd0);
        exec(1'b0, 3'b010, 32'h20, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
